// File: rtl/glyph_pkg.sv
// glyph_pkg: shared font geometry, FSM state encoding and printable-code range
// for the glyph renderer.
package glyph_pkg;

  localparam int DEF_FONT_W = 5;
  localparam int DEF_FONT_H = 7;
  localparam int GLYPH_BITS = DEF_FONT_W * DEF_FONT_H;

  localparam logic [7:0] GLYPH_FIRST = 8'h20;
  localparam logic [7:0] GLYPH_LAST  = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational ASCII-to-bitmap font, 5x7 rows packed MSB-first
// (MSB = top-left pixel). Codes outside the printable range render blank.
module glyph_rom
  import glyph_pkg::*;
#(
  parameter int CHAR_W = 7
) (
  input  logic [CHAR_W-1:0]     char,
  output logic [GLYPH_BITS-1:0] glyph
);

  localparam int PAD_W = (CHAR_W > 8) ? CHAR_W : 8;

  logic [PAD_W-1:0] wide_s;
  logic [7:0]       code_s;

  // Range-check the code so wide codes never alias onto a printable glyph
  always_comb begin
    wide_s = PAD_W'(char);
    if ((wide_s >= PAD_W'(GLYPH_FIRST)) && (wide_s <= PAD_W'(GLYPH_LAST))) begin
      code_s = wide_s[7:0];
    end else begin
      code_s = 8'h00;
    end
  end

  // Font table
  always_comb begin
    case (code_s)
      8'h20: glyph = 35'b00000_00000_00000_00000_00000_00000_00000;
      8'h21: glyph = 35'b00100_00100_00100_00100_00100_00000_00100;
      8'h22: glyph = 35'b01010_01010_01010_00000_00000_00000_00000;
      8'h23: glyph = 35'b01010_01010_11111_01010_11111_01010_01010;
      8'h24: glyph = 35'b00100_01111_10100_01110_00101_11110_00100;
      8'h25: glyph = 35'b11000_11001_00010_00100_01000_10011_00011;
      8'h26: glyph = 35'b01100_10010_10100_01000_10101_10010_01101;
      8'h27: glyph = 35'b01100_00100_01000_00000_00000_00000_00000;
      8'h28: glyph = 35'b00010_00100_01000_01000_01000_00100_00010;
      8'h29: glyph = 35'b01000_00100_00010_00010_00010_00100_01000;
      8'h2A: glyph = 35'b00000_00100_10101_01110_10101_00100_00000;
      8'h2B: glyph = 35'b00000_00100_00100_11111_00100_00100_00000;
      8'h2C: glyph = 35'b00000_00000_00000_00000_01100_00100_01000;
      8'h2D: glyph = 35'b00000_00000_00000_11111_00000_00000_00000;
      8'h2E: glyph = 35'b00000_00000_00000_00000_00000_01100_01100;
      8'h2F: glyph = 35'b00000_00001_00010_00100_01000_10000_00000;
      8'h30: glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
      8'h31: glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
      8'h32: glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
      8'h33: glyph = 35'b11111_00010_00100_00010_00001_10001_01110;
      8'h34: glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
      8'h35: glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
      8'h36: glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
      8'h37: glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
      8'h38: glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
      8'h39: glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
      8'h3A: glyph = 35'b00000_01100_01100_00000_01100_01100_00000;
      8'h3B: glyph = 35'b00000_01100_01100_00000_01100_00100_01000;
      8'h3C: glyph = 35'b00010_00100_01000_10000_01000_00100_00010;
      8'h3D: glyph = 35'b00000_00000_11111_00000_11111_00000_00000;
      8'h3E: glyph = 35'b01000_00100_00010_00001_00010_00100_01000;
      8'h3F: glyph = 35'b01110_10001_00001_00010_00100_00000_00100;
      8'h40: glyph = 35'b01110_10001_00001_01101_10101_10101_01110;
      8'h41: glyph = 35'b01110_10001_10001_10001_11111_10001_10001;
      8'h42: glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
      8'h43: glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
      8'h44: glyph = 35'b11100_10010_10001_10001_10001_10010_11100;
      8'h45: glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
      8'h46: glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
      8'h47: glyph = 35'b01110_10001_10000_10111_10001_10001_01111;
      8'h48: glyph = 35'b10001_10001_10001_11111_10001_10001_10001;
      8'h49: glyph = 35'b01110_00100_00100_00100_00100_00100_01110;
      8'h4A: glyph = 35'b00111_00010_00010_00010_00010_10010_01100;
      8'h4B: glyph = 35'b10001_10010_10100_11000_10100_10010_10001;
      8'h4C: glyph = 35'b10000_10000_10000_10000_10000_10000_11111;
      8'h4D: glyph = 35'b10001_11011_10101_10101_10001_10001_10001;
      8'h4E: glyph = 35'b10001_10001_11001_10101_10011_10001_10001;
      8'h4F: glyph = 35'b01110_10001_10001_10001_10001_10001_01110;
      8'h50: glyph = 35'b11110_10001_10001_11110_10000_10000_10000;
      8'h51: glyph = 35'b01110_10001_10001_10001_10101_10010_01101;
      8'h52: glyph = 35'b11110_10001_10001_11110_10100_10010_10001;
      8'h53: glyph = 35'b01111_10000_10000_01110_00001_00001_11110;
      8'h54: glyph = 35'b11111_00100_00100_00100_00100_00100_00100;
      8'h55: glyph = 35'b10001_10001_10001_10001_10001_10001_01110;
      8'h56: glyph = 35'b10001_10001_10001_10001_10001_01010_00100;
      8'h57: glyph = 35'b10001_10001_10001_10101_10101_10101_01010;
      8'h58: glyph = 35'b10001_10001_01010_00100_01010_10001_10001;
      8'h59: glyph = 35'b10001_10001_10001_01010_00100_00100_00100;
      8'h5A: glyph = 35'b11111_00001_00010_00100_01000_10000_11111;
      8'h5B: glyph = 35'b01110_01000_01000_01000_01000_01000_01110;
      8'h5C: glyph = 35'b00000_10000_01000_00100_00010_00001_00000;
      8'h5D: glyph = 35'b01110_00010_00010_00010_00010_00010_01110;
      8'h5E: glyph = 35'b00100_01010_10001_00000_00000_00000_00000;
      8'h5F: glyph = 35'b00000_00000_00000_00000_00000_00000_11111;
      8'h60: glyph = 35'b01000_00100_00010_00000_00000_00000_00000;
      8'h61: glyph = 35'b00000_00000_01110_00001_01111_10001_01111;
      8'h62: glyph = 35'b10000_10000_10110_11001_10001_10001_11110;
      8'h63: glyph = 35'b00000_00000_01110_10000_10000_10001_01110;
      8'h64: glyph = 35'b00001_00001_01101_10011_10001_10001_01111;
      8'h65: glyph = 35'b00000_00000_01110_10001_11111_10000_01110;
      8'h66: glyph = 35'b00110_01001_01000_11100_01000_01000_01000;
      8'h67: glyph = 35'b00000_01111_10001_10001_01111_00001_01110;
      8'h68: glyph = 35'b10000_10000_10110_11001_10001_10001_10001;
      8'h69: glyph = 35'b00100_00000_01100_00100_00100_00100_01110;
      8'h6A: glyph = 35'b00010_00000_00110_00010_00010_10010_01100;
      8'h6B: glyph = 35'b10000_10000_10010_10100_11000_10100_10010;
      8'h6C: glyph = 35'b01100_00100_00100_00100_00100_00100_01110;
      8'h6D: glyph = 35'b00000_00000_11010_10101_10101_10001_10001;
      8'h6E: glyph = 35'b00000_00000_10110_11001_10001_10001_10001;
      8'h6F: glyph = 35'b00000_00000_01110_10001_10001_10001_01110;
      8'h70: glyph = 35'b00000_00000_11110_10001_11110_10000_10000;
      8'h71: glyph = 35'b00000_00000_01101_10011_01111_00001_00001;
      8'h72: glyph = 35'b00000_00000_10110_11001_10000_10000_10000;
      8'h73: glyph = 35'b00000_00000_01110_10000_01110_00001_11110;
      8'h74: glyph = 35'b01000_01000_11100_01000_01000_01001_00110;
      8'h75: glyph = 35'b00000_00000_10001_10001_10001_10011_01101;
      8'h76: glyph = 35'b00000_00000_10001_10001_10001_01010_00100;
      8'h77: glyph = 35'b00000_00000_10001_10001_10101_10101_01010;
      8'h78: glyph = 35'b00000_00000_10001_01010_00100_01010_10001;
      8'h79: glyph = 35'b00000_00000_10001_10001_01111_00001_01110;
      8'h7A: glyph = 35'b00000_00000_11111_00010_00100_01000_11111;
      8'h7B: glyph = 35'b00010_00100_00100_01000_00100_00100_00010;
      8'h7C: glyph = 35'b00100_00100_00100_00100_00100_00100_00100;
      8'h7D: glyph = 35'b01000_00100_00100_00010_00100_00100_01000;
      8'h7E: glyph = 35'b00000_00000_01000_10101_00010_00000_00000;
      default: glyph = {GLYPH_BITS{1'b0}};
    endcase
  end

endmodule

// File: rtl/glyph_renderer.sv
// glyph_renderer: latches one character and walks its scaled cell in raster order,
// one pixel per cycle over valid/ready. Define GLYPH_BG_FILL_EN to also emit background pixels.
module glyph_renderer
  import glyph_pkg::*;
#(
  parameter int FONT_W  = DEF_FONT_W,
  parameter int FONT_H  = DEF_FONT_H,
  parameter int CHAR_W  = 7,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int SCALE_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CHAR_W-1:0]  char,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  logic [SCALE_W-1:0] scale,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [X_W-1:0]     out_x,
  output logic [Y_W-1:0]     out_y,
  output logic               out_fg,
  output logic               busy,
  output logic               done
);

  localparam int BITS  = FONT_W * FONT_H;
  localparam int IDX_W = $clog2(BITS);
  localparam int R_W   = $clog2(FONT_H);
  localparam int C_W   = $clog2(FONT_W);

  state_t               state_r, state_nx_s;
  logic [CHAR_W-1:0]    char_r;
  logic [X_W-1:0]       ox_r, col_base_r, col_base_nx_s, x_s, out_x_r;
  logic [Y_W-1:0]       oy_r, row_base_r, row_base_nx_s, y_s, out_y_r;
  logic [SCALE_W-1:0]   scale_r, scale_m1_s;
  logic [SCALE_W-1:0]   sy_r, sy_nx_s, sx_r, sx_nx_s;
  logic [R_W-1:0]       r_r, r_nx_s;
  logic [C_W-1:0]       c_r, c_nx_s;
  logic [IDX_W-1:0]     idx_r, idx_nx_s;
  logic [BITS-1:0]      bitmap_r, bitmap_nx_s;
  logic [GLYPH_BITS-1:0] rom_s;
  logic                 advance_s, last_s, sx_end_s, c_end_s, sy_end_s, r_end_s;
  logic                 done_nx_s, pix_s, emit_s, fg_s;
  logic                 out_valid_r, out_fg_r, busy_r, done_r;

  glyph_rom #(.CHAR_W(CHAR_W)) u_rom (
    .char  (char_r),
    .glyph (rom_s)
  );

  assign scale_m1_s = scale_r - SCALE_W'(1'b1);
  assign sx_end_s   = (sx_r == scale_m1_s);
  assign sy_end_s   = (sy_r == scale_m1_s);
  assign c_end_s    = (c_r == C_W'(FONT_W - 1));
  assign r_end_s    = (r_r == R_W'(FONT_H - 1));
  assign last_s     = r_end_s & sy_end_s & c_end_s & sx_end_s;
  assign advance_s  = !out_valid_r || out_ready;

  // Next state and walker step: sx innermost, then c, then sy, then r
  always_comb begin
    state_nx_s    = state_r;
    r_nx_s        = r_r;
    c_nx_s        = c_r;
    sy_nx_s       = sy_r;
    sx_nx_s       = sx_r;
    col_base_nx_s = col_base_r;
    row_base_nx_s = row_base_r;
    idx_nx_s      = idx_r;
    bitmap_nx_s   = bitmap_r;
    done_nx_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_LOAD;
        else       state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        state_nx_s    = ST_RUN;
        r_nx_s        = {R_W{1'b0}};
        c_nx_s        = {C_W{1'b0}};
        sy_nx_s       = {SCALE_W{1'b0}};
        sx_nx_s       = {SCALE_W{1'b0}};
        col_base_nx_s = ox_r;
        row_base_nx_s = oy_r;
        idx_nx_s      = IDX_W'(BITS - 1);
        bitmap_nx_s   = BITS'(rom_s);
      end
      ST_RUN: begin
        if (!advance_s) begin
          state_nx_s = ST_RUN;
        end else if (last_s) begin
          state_nx_s = ST_DONE;
          done_nx_s  = 1'b1;
        end else if (!sx_end_s) begin
          sx_nx_s = sx_r + SCALE_W'(1'b1);
        end else begin
          sx_nx_s = {SCALE_W{1'b0}};
          if (!c_end_s) begin
            c_nx_s        = c_r + C_W'(1'b1);
            col_base_nx_s = col_base_r + X_W'(scale_r);
            idx_nx_s      = idx_r - IDX_W'(1'b1);
          end else begin
            // Row pass finished: rewind to column 0, either repeat the row or move down
            c_nx_s        = {C_W{1'b0}};
            col_base_nx_s = ox_r;
            if (!sy_end_s) begin
              sy_nx_s  = sy_r + SCALE_W'(1'b1);
              idx_nx_s = idx_r + IDX_W'(FONT_W - 1);
            end else begin
              sy_nx_s       = {SCALE_W{1'b0}};
              r_nx_s        = r_r + R_W'(1'b1);
              row_base_nx_s = row_base_r + Y_W'(scale_r);
              idx_nx_s      = idx_r - IDX_W'(1'b1);
            end
          end
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Pixel lookup and emit decision for the position entering the output registers
  always_comb begin
    pix_s = bitmap_nx_s[idx_nx_s];
    x_s   = col_base_nx_s + X_W'(sx_nx_s);
    y_s   = row_base_nx_s + Y_W'(sy_nx_s);
`ifdef GLYPH_BG_FILL_EN
    emit_s = 1'b1;
    fg_s   = pix_s;
`else
    emit_s = pix_s;
    fg_s   = 1'b1;
`endif
  end

  // FSM, walker counters and latched request
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      char_r     <= {CHAR_W{1'b0}};
      ox_r       <= {X_W{1'b0}};
      oy_r       <= {Y_W{1'b0}};
      scale_r    <= SCALE_W'(1'b1);
      r_r        <= {R_W{1'b0}};
      c_r        <= {C_W{1'b0}};
      sy_r       <= {SCALE_W{1'b0}};
      sx_r       <= {SCALE_W{1'b0}};
      col_base_r <= {X_W{1'b0}};
      row_base_r <= {Y_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      bitmap_r   <= {BITS{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      r_r        <= r_nx_s;
      c_r        <= c_nx_s;
      sy_r       <= sy_nx_s;
      sx_r       <= sx_nx_s;
      col_base_r <= col_base_nx_s;
      row_base_r <= row_base_nx_s;
      idx_r      <= idx_nx_s;
      bitmap_r   <= bitmap_nx_s;
      if ((state_r == ST_IDLE) && start) begin
        char_r  <= char;
        ox_r    <= origin_x;
        oy_r    <= origin_y;
        scale_r <= (scale == {SCALE_W{1'b0}}) ? SCALE_W'(1'b1) : scale;
      end
    end
  end

  // Registered outputs; a stalled slot recomputes the same values so they hold
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_x_r     <= {X_W{1'b0}};
      out_y_r     <= {Y_W{1'b0}};
      out_fg_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (state_nx_s == ST_RUN) begin
        out_valid_r <= emit_s;
        out_x_r     <= x_s;
        out_y_r     <= y_s;
        out_fg_r    <= emit_s & fg_s;
      end else begin
        out_valid_r <= 1'b0;
        out_fg_r    <= 1'b0;
      end
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= done_nx_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_x     = out_x_r;
  assign out_y     = out_y_r;
  assign out_fg    = out_fg_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_glyph_renderer.sv
// tb_glyph_renderer: table-driven directed bench for glyph_renderer plus hand-written
// reset and start-during-run sequences. Follows GLYPH_BG_FILL_EN when defined.
module tb_glyph_renderer;

  localparam int CHAR_W  = 7;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int SCALE_W = 3;
`ifdef GLYPH_BG_FILL_EN
  localparam bit BG = 1'b1;
`else
  localparam bit BG = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [CHAR_W-1:0]  char;
  logic [X_W-1:0]     origin_x;
  logic [Y_W-1:0]     origin_y;
  logic [SCALE_W-1:0] scale;
  logic               out_ready;
  logic               out_valid;
  logic [X_W-1:0]     out_x;
  logic [Y_W-1:0]     out_y;
  logic               out_fg;
  logic               busy;
  logic               done;

  int n_cmp = 0;
  int n_bad = 0;

  glyph_renderer dut (
    .clock(clock), .reset(reset), .start(start), .char(char),
    .origin_x(origin_x), .origin_y(origin_y), .scale(scale),
    .out_ready(out_ready), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .out_fg(out_fg), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] ch;
    int ox;
    int oy;
    int sc;
    int stall;
    int poke;
    int exp_cnt;
    int exp_done;
  } vec_t;

  typedef struct {
    int x;
    int y;
    bit fg;
  } px_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] ref_bitmap(input logic [6:0] ch);
    logic [34:0] bm;
    if (ch == 7'h41) bm = 35'b01110_10001_10001_10001_11111_10001_10001;
    else             bm = 35'd0;
    return bm;
  endfunction

  function automatic bit rdy(input int mode, input int n);
    if (mode == 0) return 1'b1;
    return ((n % 4) == 0) || ((n % 4) == 3);
  endfunction

  function automatic int pk(input int x, input int y, input bit fg);
    return (x << 8) | (y << 1) | int'(fg);
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    px_t         q[$];
    px_t         p;
    logic [34:0] bm, sh;
    int          s, got, done_n, n, prev;
    bit          stalled, prev_v;
    s  = (v.sc == 0) ? 1 : v.sc;
    bm = ref_bitmap(v.ch);
    for (int r = 0; r < 7; r++)
      for (int sy = 0; sy < s; sy++)
        for (int c = 0; c < 5; c++)
          for (int sx = 0; sx < s; sx++) begin
            sh   = bm << (r * 5 + c);
            p.x  = (v.ox + c * s + sx) % 256;
            p.y  = (v.oy + r * s + sy) % 128;
            p.fg = BG ? sh[34] : 1'b1;
            if (BG || sh[34]) q.push_back(p);
          end
    @(negedge clock);
    char = v.ch; origin_x = X_W'(v.ox); origin_y = Y_W'(v.oy); scale = SCALE_W'(v.sc);
    start = 1'b1;
    @(negedge clock);
    n = 1; got = 0; done_n = -1; stalled = 1'b0; prev = 0; prev_v = 1'b0;
    check({tag, " busy in LOAD"}, int'(busy), 1);
    while (n < 3000) begin
      out_ready = rdy(v.stall, n);
      if (v.poke != 0 && n == 10) begin start = 1'b1; char = 7'h48; end
      else start = 1'b0;
      if (done) begin done_n = n; break; end
      if (stalled) begin
        check({tag, " stall hold"}, pk(int'(out_x), int'(out_y), out_fg), prev);
        check({tag, " stall valid"}, int'(out_valid), int'(prev_v));
      end
      if (out_valid && out_ready) begin
        if (got < q.size()) check({tag, " pixel"}, pk(int'(out_x), int'(out_y), out_fg),
                                  pk(q[got].x, q[got].y, q[got].fg));
        got++;
      end
      stalled = out_valid && !out_ready;
      prev    = pk(int'(out_x), int'(out_y), out_fg);
      prev_v  = out_valid;
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check({tag, " done cycle"}, done_n, v.exp_done);
    check({tag, " pixel count"}, got, v.exp_cnt);
    check({tag, " busy at done"}, int'(busy), 1);
    out_ready = 1'b1;
    @(negedge clock);
    check({tag, " busy after"}, int'(busy), 0);
    check({tag, " done width"}, int'(done), 0);
    if (v.poke != 0) begin
      repeat (4) @(negedge clock);
      check({tag, " start ignored"}, int'(busy), 0);
      check({tag, " no valid idle"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    int dones;
    vecs[0] = '{7'h41, 10,  20,  1, 0, 0, BG ? 35  : 18, 37};
    vecs[1] = '{7'h41, 0,   0,   2, 0, 0, BG ? 140 : 72, 142};
    vecs[2] = '{7'h20, 5,   5,   3, 0, 0, BG ? 315 : 0,  317};
    vecs[3] = '{7'h41, 10,  20,  1, 1, 0, BG ? 35  : 18, BG ? 72 : 49};
    vecs[4] = '{7'h41, 254, 0,   2, 0, 0, BG ? 140 : 72, 142};
    vecs[5] = '{7'h7F, 3,   3,   0, 0, 0, BG ? 35  : 0,  37};
    vecs[6] = '{7'h41, 0,   124, 1, 0, 1, BG ? 35  : 18, 37};

    reset = 1'b1; start = 1'b0; char = 7'h00; origin_x = 8'd0; origin_y = 7'd0;
    scale = 3'd1; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_x", int'(out_x), 0);
    check("reset out_y", int'(out_y), 0);
    check("reset out_fg", int'(out_fg), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a scale-2 render
    @(negedge clock);
    char = 7'h41; origin_x = 8'd0; origin_y = 7'd0; scale = 3'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    check("midrun busy before reset", int'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrun reset busy", int'(busy), 0);
    check("midrun reset valid", int'(out_valid), 0);
    check("midrun reset done", int'(done), 0);
    dones = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      if (done || busy) dones++;
    end
    check("midrun no activity after reset", dones, 0);

    run_vec(vecs[0], "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
